pipe_ctrl_flush: RTL and testbench

PIPE_CTRL_FLUSH -- requirements
Module: pipe_ctrl_flush

---
 rtl/pipe_ctrl_flush_if.sv | 24 ++
 rtl/pipe_ctrl_flush.sv | 73 +++++++
 tb/tb_pipe_ctrl_flush.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_flush_if.sv
// pipe_ctrl_flush_if: decode-stage bundle between the pipeline and its control/flush unit.
interface pipe_ctrl_flush_if;
    logic [31:0] INST;
    logic        wrong;
    logic        stall;
    logic        RegWE;
    logic [3:0]  ALUOP;
    logic        ALUsrcA;
    logic        ALUsrcB;
    logic [2:0]  Immsrc;
    logic        MemWE;
    logic        MemLD;
    logic        PCsrc;
    logic        squash;
    logic        ill;
    modport master (
        output INST, wrong, stall,
        input  RegWE, ALUOP, ALUsrcA, ALUsrcB, Immsrc, MemWE, MemLD, PCsrc, squash, ill
    );
    modport slave (
        input  INST, wrong, stall,
        output RegWE, ALUOP, ALUsrcA, ALUsrcB, Immsrc, MemWE, MemLD, PCsrc, squash, ill
    );
endinterface

// File: rtl/pipe_ctrl_flush.sv
// pipe_ctrl_flush: combinational instruction decode with a redirect-driven squash window.
module pipe_ctrl_flush #(
    parameter int FLUSH_DEPTH = 1,
    parameter int EN_CUSTOM   = 1
) (
    input  logic              CLK,
    input  logic              RSTn,
    pipe_ctrl_flush_if.slave  b
);
    logic [2:0] cnt;
    logic       pend;
    logic [6:0] op;
    logic [2:0] f3;
    logic [3:0] aluop;
    logic [2:0] imm;
    logic       a_sel, b_sel, pcs, rwe, mwe, mld, ill_d;
    logic       unused;
    assign op     = b.INST[6:0];
    assign f3     = b.INST[14:12];
    assign unused = ^{b.INST[31], b.INST[29:26], b.INST[24:15], b.INST[11:7]};
    always_comb begin
        aluop = '0;
        imm   = '0;
        a_sel = 1'b1;
        b_sel = 1'b1;
        pcs   = 1'b1;
        rwe   = 1'b0;
        mwe   = 1'b0;
        mld   = 1'b0;
        ill_d = 1'b0;
        case (op)
            7'b0110011: begin aluop = {(f3 == 3'b000 || f3 == 3'b101) & b.INST[30], f3}; rwe = 1'b1; end
            7'b0010011: begin aluop = {(f3 == 3'b101) & b.INST[30], f3}; b_sel = 1'b0; rwe = 1'b1; end
            7'b0001011: begin
                if (EN_CUSTOM != 0) begin aluop = {f3, b.INST[25]}; rwe = 1'b1; end
                else ill_d = 1'b1;
            end
            7'b0100011: begin b_sel = 1'b0; imm = 3'b001; mwe = 1'b1; end
            7'b0000011: begin b_sel = 1'b0; mld = 1'b1; rwe = 1'b1; end
            7'b1100111: begin b_sel = 1'b0; pcs = 1'b0; rwe = 1'b1; end
            7'b1100011: begin a_sel = 1'b0; b_sel = 1'b0; imm = 3'b010; end
            7'b1101111: begin a_sel = 1'b0; b_sel = 1'b0; imm = 3'b011; pcs = 1'b0; rwe = 1'b1; end
            default:    ill_d = 1'b1;
        endcase
    end
    // Side-effecting enables are masked in squashed slots; the rest still follow decode.
    assign b.squash  = cnt != 3'd0;
    assign b.RegWE   = rwe & ~b.squash;
    assign b.MemWE   = mwe & ~b.squash;
    assign b.MemLD   = mld & ~b.squash;
    assign b.ill     = ill_d & ~b.squash;
    assign b.ALUOP   = aluop;
    assign b.ALUsrcA = a_sel;
    assign b.ALUsrcB = b_sel;
    assign b.Immsrc  = imm;
    assign b.PCsrc   = pcs;
    // A redirect seen during a stall is remembered and launches the flush once the pipe moves.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            cnt  <= '0;
            pend <= 1'b0;
        end else if (!b.stall) begin
            if (cnt == 3'd0 && (b.wrong || pend)) begin
                cnt  <= 3'(FLUSH_DEPTH);
                pend <= 1'b0;
            end else if (cnt != 3'd0) begin
                cnt <= cnt - 3'd1;
            end
        end else if (b.wrong && cnt == 3'd0) begin
            pend <= 1'b1;
        end
    end
endmodule

// File: tb/tb_pipe_ctrl_flush.sv
// tb_pipe_ctrl_flush: three flush depths side by side against a behavioural model.
module tb_pipe_ctrl_flush;
    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic [31:0] inst = 32'h0000_0033;
    logic        wrong = 1'b0;
    logic        stall = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int          depth [3] = '{1, 2, 3};
    bit          ecust [3] = '{1'b1, 1'b0, 1'b1};
    int          left [3];
    bit          pend_m [3];
    logic [14:0] obs [3];

    always #5 CLK = ~CLK;

    pipe_ctrl_flush_if b1 ();
    pipe_ctrl_flush_if b2 ();
    pipe_ctrl_flush_if b3 ();
    assign b1.INST = inst; assign b1.wrong = wrong; assign b1.stall = stall;
    assign b2.INST = inst; assign b2.wrong = wrong; assign b2.stall = stall;
    assign b3.INST = inst; assign b3.wrong = wrong; assign b3.stall = stall;

    pipe_ctrl_flush #(.FLUSH_DEPTH(1), .EN_CUSTOM(1)) u1 (.CLK(CLK), .RSTn(RSTn), .b(b1.slave));
    pipe_ctrl_flush #(.FLUSH_DEPTH(2), .EN_CUSTOM(0)) u2 (.CLK(CLK), .RSTn(RSTn), .b(b2.slave));
    pipe_ctrl_flush #(.FLUSH_DEPTH(3), .EN_CUSTOM(1)) u3 (.CLK(CLK), .RSTn(RSTn), .b(b3.slave));

    assign obs[0] = {b1.RegWE, b1.ALUOP, b1.ALUsrcA, b1.ALUsrcB, b1.Immsrc, b1.MemWE, b1.MemLD, b1.PCsrc, b1.squash, b1.ill};
    assign obs[1] = {b2.RegWE, b2.ALUOP, b2.ALUsrcA, b2.ALUsrcB, b2.Immsrc, b2.MemWE, b2.MemLD, b2.PCsrc, b2.squash, b2.ill};
    assign obs[2] = {b3.RegWE, b3.ALUOP, b3.ALUsrcA, b3.ALUsrcB, b3.Immsrc, b3.MemWE, b3.MemLD, b3.PCsrc, b3.squash, b3.ill};

    // Decode table as written in the opcode class list; packed like obs with squash=0.
    function automatic logic [14:0] decode(input logic [31:0] i, input bit ec);
        logic [2:0] f;
        logic [3:0] alu;
        logic [2:0] im;
        logic rw, a, bb, mw, ml, pc, il;
        f = i[14:12];
        alu = 4'd0; im = 3'd0; a = 1; bb = 1; pc = 1; rw = 0; mw = 0; ml = 0; il = 0;
        if (i[6:0] == 7'b0110011) begin
            alu = {((f == 3'd0) || (f == 3'd5)) ? i[30] : 1'b0, f}; rw = 1;
        end else if (i[6:0] == 7'b0010011) begin
            alu = {(f == 3'd5) ? i[30] : 1'b0, f}; bb = 0; rw = 1;
        end else if (i[6:0] == 7'b0001011 && ec) begin
            alu = {f, i[25]}; rw = 1;
        end else if (i[6:0] == 7'b0100011) begin
            bb = 0; im = 3'b001; mw = 1;
        end else if (i[6:0] == 7'b0000011) begin
            bb = 0; ml = 1; rw = 1;
        end else if (i[6:0] == 7'b1100111) begin
            bb = 0; pc = 0; rw = 1;
        end else if (i[6:0] == 7'b1100011) begin
            a = 0; bb = 0; im = 3'b010;
        end else if (i[6:0] == 7'b1101111) begin
            a = 0; bb = 0; im = 3'b011; pc = 0; rw = 1;
        end else begin
            il = 1;
        end
        return {rw, alu, a, bb, im, mw, ml, pc, 1'b0, il};
    endfunction

    function automatic logic [14:0] expect_out(input int k);
        logic [14:0] e;
        e = decode(inst, ecust[k]);
        if (left[k] > 0) begin
            e[14] = 0; e[4] = 0; e[3] = 0; e[0] = 0; e[1] = 1;
        end
        return e;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin left[k] = 0; pend_m[k] = 0; end
    endtask

    // One clock: the model applies the flush rules to the inputs present at the edge.
    task automatic tick();
        @(posedge CLK);
        for (int k = 0; k < 3; k++) begin
            if (!RSTn) begin
                left[k] = 0; pend_m[k] = 0;
            end else if (!stall) begin
                if (left[k] == 0 && (wrong || pend_m[k])) begin left[k] = depth[k]; pend_m[k] = 0; end
                else if (left[k] > 0) left[k] = left[k] - 1;
            end else if (wrong && left[k] == 0) begin
                pend_m[k] = 1;
            end
        end
        @(negedge CLK);
    endtask

    task automatic idle(input int n);
        wrong = 0; stall = 0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        RSTn = 0; inst = 32'h4000_0033; model_reset();
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs[k] !== expect_out(k)) begin
                errors++; $display("FAIL reset_decode dut%0d got %h exp %h", k, obs[k], expect_out(k));
            end
        end
        checks++;
        if (b1.ALUOP !== 4'b1000) begin errors++; $display("FAIL reset_sub_aluop got %b exp 1000", b1.ALUOP); end
        @(negedge CLK); RSTn = 1;
        idle(2);
    endtask

    task automatic test_depth1();
        inst = 32'h0000_0033; wrong = 1;
        tick();
        wrong = 0; #1;
        checks++;
        if (b1.squash !== 1'b1 || b1.RegWE !== 1'b0) begin
            errors++; $display("FAIL d1_squash got sq=%b we=%b exp sq=1 we=0", b1.squash, b1.RegWE);
        end
        tick(); #1;
        checks++;
        if (b1.squash !== 1'b0 || b1.RegWE !== 1'b1) begin
            errors++; $display("FAIL d1_after got sq=%b we=%b exp sq=0 we=1", b1.squash, b1.RegWE);
        end
        idle(4);
    endtask

    task automatic test_depth3_store();
        inst = 32'h0020_a023; wrong = 1;
        tick();
        wrong = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (b3.squash !== (i < 3) || b3.MemWE !== (i >= 3)) begin
                errors++; $display("FAIL d3_store slot%0d got sq=%b mwe=%b exp sq=%b mwe=%b", i, b3.squash, b3.MemWE, i < 3, i >= 3);
            end
            tick();
        end
        idle(3);
    endtask

    task automatic test_stall_pend();
        inst = 32'h0000_0013; wrong = 1; stall = 1;
        tick(); tick();
        wrong = 0; stall = 0; #1;
        checks++;
        if (b2.squash !== 1'b0) begin errors++; $display("FAIL pend_early got %b exp 0", b2.squash); end
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            checks++;
            if (b2.squash !== (i < 2)) begin
                errors++; $display("FAIL pend_slot%0d got %b exp %b", i, b2.squash, i < 2);
            end
        end
        idle(3);
    endtask

    task automatic test_wrong_ignored();
        inst = 32'h0000_0033; wrong = 1;
        tick();
        wrong = 0; #1;
        checks++;
        if (b2.squash !== 1'b1) begin errors++; $display("FAIL ign_slot0 got %b exp 1", b2.squash); end
        tick();
        wrong = 1; #1;
        checks++;
        if (b2.squash !== 1'b1) begin errors++; $display("FAIL ign_slot1 got %b exp 1", b2.squash); end
        tick();
        wrong = 0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (b2.squash !== 1'b0) begin errors++; $display("FAIL ign_after%0d got %b exp 0", i, b2.squash); end
            tick();
        end
        idle(4);
    endtask

    task automatic test_custom();
        inst = 32'h0200_200b; #1;
        checks++;
        if (b2.RegWE !== 1'b0 || b2.ill !== 1'b1) begin
            errors++; $display("FAIL custom_off got we=%b ill=%b exp we=0 ill=1", b2.RegWE, b2.ill);
        end
        checks++;
        if (b1.ALUOP !== 4'b0101 || b1.RegWE !== 1'b1 || b1.ill !== 1'b0) begin
            errors++; $display("FAIL custom_on got op=%b we=%b ill=%b exp op=0101 we=1 ill=0", b1.ALUOP, b1.RegWE, b1.ill);
        end
        tick();
    endtask

    task automatic test_async_reset();
        inst = 32'h0000_0033; wrong = 1;
        tick();
        wrong = 0;
        tick();
        checks++;
        if (b3.squash !== 1'b1) begin errors++; $display("FAIL ar_before got %b exp 1", b3.squash); end
        #2 RSTn = 0; model_reset();
        #1;
        checks++;
        if (b3.squash !== 1'b0 || b3.RegWE !== 1'b1) begin
            errors++; $display("FAIL ar_async got sq=%b we=%b exp sq=0 we=1", b3.squash, b3.RegWE);
        end
        @(negedge CLK); RSTn = 1; inst = 32'h0000_006f; #1;
        checks++;
        if (b1.PCsrc !== 1'b0 || b1.RegWE !== 1'b1) begin
            errors++; $display("FAIL ar_jal got pc=%b we=%b exp pc=0 we=1", b1.PCsrc, b1.RegWE);
        end
        tick(); #1;
        checks++;
        if (b3.squash !== 1'b0) begin errors++; $display("FAIL ar_resume got %b exp 0", b3.squash); end
        idle(1);
    endtask

    task automatic test_random();
        logic [6:0] ops [10] = '{7'b0110011, 7'b0010011, 7'b0001011, 7'b0100011, 7'b0000011,
                                 7'b1100111, 7'b1100011, 7'b1101111, 7'b1111111, 7'b0110111};
        logic [31:0] r;
        for (int n = 0; n < 400; n++) begin
            r = $urandom();
            inst  = {r[31:7], ops[$urandom_range(0, 9)]};
            wrong = ($urandom_range(0, 3) == 0);
            stall = ($urandom_range(0, 4) == 0);
            #1;
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs[k] !== expect_out(k)) begin
                    errors++; $display("FAIL rand n%0d dut%0d inst %h got %h exp %h", n, k, inst, obs[k], expect_out(k));
                end
            end
            tick();
        end
        idle(4);
    endtask

    initial begin
        test_reset();
        test_depth1();
        test_depth3_store();
        test_stall_pend();
        test_wrong_ignored();
        test_custom();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
